// File: rtl/bc_pkg.sv
// Shared definitions for the basic-computer I/O and interrupt controller.
package bc_pkg;

  localparam int IO_WIDTH_DEF = 8;

  // Bit positions within io_op (IR[11:6]); higher index wins when several are set.
  localparam int OP_INP = 5;
  localparam int OP_OUT = 4;
  localparam int OP_SKI = 3;
  localparam int OP_SKO = 2;
  localparam int OP_ION = 1;
  localparam int OP_IOF = 0;

  typedef enum logic [1:0] {IDLE, RT0, RT1, RT2} intr_state_t;

  typedef enum logic [2:0] {
    IO_NONE, IO_INP, IO_OUT, IO_SKI, IO_SKO, IO_ION, IO_IOF
  } io_cmd_t;

  // Reduce the io_op field to the single command it selects.
  function automatic io_cmd_t decode_op(input logic [5:0] op);
    io_cmd_t c;
    c = IO_NONE;
    if      (op[OP_INP]) c = IO_INP;
    else if (op[OP_OUT]) c = IO_OUT;
    else if (op[OP_SKI]) c = IO_SKI;
    else if (op[OP_SKO]) c = IO_SKO;
    else if (op[OP_ION]) c = IO_ION;
    else if (op[OP_IOF]) c = IO_IOF;
    return c;
  endfunction

endpackage

// File: rtl/io_flag_port.sv
// Data register plus status flag; used for both the keyboard (INPR/FGI)
// and the printer (OUTR/FGO) sides.
module io_flag_port #(
  parameter int   W        = 8,
  parameter logic FLAG_RST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] ld_data,
  input  logic         set,
  input  logic         clr,
  output logic [W-1:0] data,
  output logic         flag
);

  logic [W-1:0] data_q, data_d;
  logic         flag_q, flag_d;

  // Next state: set beats clear so a simultaneous event is never lost.
  always_comb begin
    data_d = ld ? ld_data : data_q;
    flag_d = flag_q;
    if (set)      flag_d = 1'b1;
    else if (clr) flag_d = 1'b0;
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      flag_q <= FLAG_RST;
    end else begin
      data_q <= data_d;
      flag_q <= flag_d;
    end
  end

  assign data = data_q;
  assign flag = flag_q;

endmodule

// File: rtl/io_intr_ctrl.sv
// I/O instruction execution and interrupt-cycle sequencer for the
// 16-bit basic computer. Owns INPR, OUTR, FGI, FGO, IEN and R.
module io_intr_ctrl
  import bc_pkg::*;
#(
  parameter int          IO_WIDTH = IO_WIDTH_DEF,
  parameter logic [11:0] VEC_ADDR = 12'h000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                io_exec,
  input  logic [5:0]          io_op,
  input  logic                instr_end,
  input  logic [IO_WIDTH-1:0] ac_lo,
  input  logic                kbd_valid,
  input  logic [IO_WIDTH-1:0] kbd_data,
  output logic                kbd_ready,
  output logic                prn_valid,
  output logic [IO_WIDTH-1:0] prn_data,
  input  logic                prn_ready,
  output logic [IO_WIDTH-1:0] inpr,
  output logic                ac_ld_inpr,
  output logic                pc_skip,
  output logic                intr_active,
  output logic                ar_ld_vec,
  output logic                tr_ld_pc,
  output logic                mem_wr_tr,
  output logic                pc_ld_vec,
  output logic                pc_inr,
  output logic                sc_clr,
  output logic                ien
);

  // VEC_ADDR is applied by the datapath when ar_ld_vec/pc_ld_vec fire;
  // this block only sequences the strobes.

  intr_state_t state_q, state_d;
  logic        ien_q, ien_d;
  logic        r_q, r_d;
  logic        fgi, fgo;
  io_cmd_t     cmd;
  logic        kbd_fire, prn_fire;

  assign kbd_ready = ~fgi;
  assign prn_valid = ~fgo;
  assign kbd_fire  = kbd_valid & ~fgi;
  assign prn_fire  = prn_ready & ~fgo;

  // I/O instructions are only honoured outside the interrupt cycle and never on a reset cycle.
  always_comb begin
    cmd = IO_NONE;
    if (io_exec && state_q == IDLE && !rst) cmd = decode_op(io_op);
  end

  // Keyboard side: a new character wins over a same-cycle INP clear.
  io_flag_port #(.W(IO_WIDTH), .FLAG_RST(1'b0)) u_kbd (
    .clk     (clk),
    .rst     (rst),
    .ld      (kbd_fire),
    .ld_data (kbd_data),
    .set     (kbd_fire),
    .clr     (cmd == IO_INP),
    .data    (inpr),
    .flag    (fgi)
  );

  // Printer side: OUT wins over a same-cycle printer accept so the new byte is not dropped.
  io_flag_port #(.W(IO_WIDTH), .FLAG_RST(1'b1)) u_prn (
    .clk     (clk),
    .rst     (rst),
    .ld      (cmd == IO_OUT),
    .ld_data (ac_lo),
    .set     (prn_fire & (cmd != IO_OUT)),
    .clr     (cmd == IO_OUT),
    .data    (prn_data),
    .flag    (fgo)
  );

  // Same-cycle decode strobes.
  always_comb begin
    ac_ld_inpr = (cmd == IO_INP);
    pc_skip    = ((cmd == IO_SKI) & fgi) | ((cmd == IO_SKO) & fgo);
  end

  // IEN next value; the interrupt cycle always leaves interrupts disabled.
  always_comb begin
    ien_d = ien_q;
    if (cmd == IO_ION) ien_d = 1'b1;
    if (cmd == IO_IOF) ien_d = 1'b0;
    if (state_q == RT2) ien_d = 1'b0;
  end

  // Interrupt FSM next state and datapath strobes; entry uses the registered IEN.
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    ar_ld_vec = 1'b0;
    tr_ld_pc  = 1'b0;
    mem_wr_tr = 1'b0;
    pc_ld_vec = 1'b0;
    pc_inr    = 1'b0;
    sc_clr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (instr_end && ien_q && (fgi || fgo)) begin
          state_d = RT0;
          r_d     = 1'b1;
        end
      end
      RT0: begin
        ar_ld_vec = !rst;
        tr_ld_pc  = !rst;
        state_d   = RT1;
      end
      RT1: begin
        mem_wr_tr = !rst;
        pc_ld_vec = !rst;
        state_d   = RT2;
      end
      RT2: begin
        pc_inr  = !rst;
        sc_clr  = !rst;
        r_d     = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ien_q   <= 1'b0;
      r_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ien_q   <= ien_d;
      r_q     <= r_d;
    end
  end

  assign intr_active = r_q;
  assign ien         = ien_q;

endmodule

// File: tb/tb_io_intr_ctrl.sv
// Directed-vector bench for io_intr_ctrl.
module tb_io_intr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       io_exec;
  logic [5:0] io_op;
  logic       instr_end;
  logic [7:0] ac_lo;
  logic       kbd_valid;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       prn_valid;
  logic [7:0] prn_data;
  logic       prn_ready;
  logic [7:0] inpr;
  logic       ac_ld_inpr, pc_skip, intr_active;
  logic       ar_ld_vec, tr_ld_pc, mem_wr_tr, pc_ld_vec, pc_inr, sc_clr;
  logic       ien;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  io_intr_ctrl #(.IO_WIDTH(8), .VEC_ADDR(12'h000)) dut (
    .clk(clk), .rst(rst), .io_exec(io_exec), .io_op(io_op),
    .instr_end(instr_end), .ac_lo(ac_lo), .kbd_valid(kbd_valid),
    .kbd_data(kbd_data), .kbd_ready(kbd_ready), .prn_valid(prn_valid),
    .prn_data(prn_data), .prn_ready(prn_ready), .inpr(inpr),
    .ac_ld_inpr(ac_ld_inpr), .pc_skip(pc_skip), .intr_active(intr_active),
    .ar_ld_vec(ar_ld_vec), .tr_ld_pc(tr_ld_pc), .mem_wr_tr(mem_wr_tr),
    .pc_ld_vec(pc_ld_vec), .pc_inr(pc_inr), .sc_clr(sc_clr), .ien(ien)
  );

  // {ar_ld_vec,tr_ld_pc,mem_wr_tr,pc_ld_vec,pc_inr,sc_clr}
  wire [5:0] stb = {ar_ld_vec, tr_ld_pc, mem_wr_tr, pc_ld_vec, pc_inr, sc_clr};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled around the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    io_exec = 0; io_op = '0; instr_end = 0; kbd_valid = 0; prn_ready = 0;
  endtask

  initial begin
    rst = 1; io_exec = 0; io_op = '0; instr_end = 0; ac_lo = '0;
    kbd_valid = 0; kbd_data = '0; prn_ready = 0;
    @(negedge clk);
    tick(); tick();
    rst = 0;
    #1;
    // Reset state
    chk("rst_prn_valid", prn_valid, 0);
    chk("rst_kbd_ready", kbd_ready, 1);
    chk("rst_intr", intr_active, 0);
    chk("rst_ien", ien, 0);
    chk("rst_inpr", inpr, 0);
    chk("rst_outr", prn_data, 0);
    chk("rst_stb", stb, 0);

    // instr_end with IEN=0 and FGO=1: no interrupt
    instr_end = 1; tick(); idle_in(); #1;
    chk("noien_intr", intr_active, 0);

    // OUT 0x41
    io_exec = 1; io_op = 6'b010000; ac_lo = 8'h41; #1;
    chk("out_no_skip", pc_skip, 0);
    tick(); idle_in(); #1;
    chk("out_data", prn_data, 8'h41);
    chk("out_valid", prn_valid, 1);
    // SKO with FGO=0 must not skip
    io_exec = 1; io_op = 6'b000100; #1;
    chk("sko_fgo0", pc_skip, 0);
    tick(); idle_in();
    prn_ready = 1; tick(); idle_in(); #1;
    chk("prn_done", prn_valid, 0);
    chk("prn_hold", prn_data, 8'h41);

    // Keyboard character 0x5A
    kbd_valid = 1; kbd_data = 8'h5A; tick(); idle_in(); #1;
    chk("kbd_ready0", kbd_ready, 0);
    chk("kbd_inpr", inpr, 8'h5A);
    io_exec = 1; io_op = 6'b001000; #1;
    chk("ski_skip", pc_skip, 1);
    chk("ski_noinp", ac_ld_inpr, 0);
    tick(); idle_in();
    io_exec = 1; io_op = 6'b100000; #1;
    chk("inp_ld", ac_ld_inpr, 1);
    chk("inp_data", inpr, 8'h5A);
    tick(); idle_in(); #1;
    chk("inp_ready", kbd_ready, 1);
    io_exec = 1; io_op = 6'b001000; #1;
    chk("ski_noskip", pc_skip, 0);
    tick(); idle_in();
    // io_op = 0 does nothing
    io_exec = 1; io_op = 6'b000000; #1;
    chk("nop_stb", {ac_ld_inpr, pc_skip}, 0);
    tick(); idle_in(); #1;
    chk("nop_ien", ien, 0);

    // Interrupt entry via pending FGO
    io_exec = 1; io_op = 6'b000010; tick(); idle_in(); #1;
    chk("ion", ien, 1);
    chk("ion_stb", stb, 0);
    instr_end = 1; tick(); idle_in(); #1;
    chk("rt0_r", intr_active, 1);
    chk("rt0_stb", stb, 6'b110000);
    tick(); #1;
    chk("rt1_stb", stb, 6'b001100);
    tick(); #1;
    chk("rt2_stb", stb, 6'b000011);
    chk("rt2_r", intr_active, 1);
    tick(); #1;
    chk("post_r", intr_active, 0);
    chk("post_ien", ien, 0);
    chk("post_stb", stb, 0);

    // Same-cycle IOF with FGI=1: interrupt still taken
    kbd_valid = 1; kbd_data = 8'h33; tick(); idle_in();
    io_exec = 1; io_op = 6'b000010; tick(); idle_in();
    io_exec = 1; io_op = 6'b000001; instr_end = 1; tick(); idle_in(); #1;
    chk("iof_taken", intr_active, 1);
    chk("iof_ien", ien, 0);
    tick();
    // RT1: io_exec INP is masked
    io_exec = 1; io_op = 6'b100000; #1;
    chk("mask_stb", stb, 6'b001100);
    chk("mask_inp", ac_ld_inpr, 0);
    tick(); idle_in(); #1;
    chk("mask_fgi", kbd_ready, 0);
    tick(); #1;
    chk("iof_end", intr_active, 0);

    // Priority: INP+SKI acts as INP only (FGI=1)
    io_exec = 1; io_op = 6'b101000; #1;
    chk("pri_inp", ac_ld_inpr, 1);
    chk("pri_skip", pc_skip, 0);
    tick(); idle_in(); #1;
    chk("pri_fgi", kbd_ready, 1);

    // Reset in the middle of RT1
    kbd_valid = 1; kbd_data = 8'h77; tick(); idle_in();
    io_exec = 1; io_op = 6'b010000; ac_lo = 8'h99; tick(); idle_in();
    io_exec = 1; io_op = 6'b000010; tick(); idle_in();
    instr_end = 1; tick(); idle_in();
    tick(); #1;
    chk("pre_rst_stb", stb, 6'b001100);
    rst = 1; #1;
    chk("rst_cyc_stb", stb, 0);
    tick(); rst = 0; #1;
    chk("mid_rst_r", intr_active, 0);
    chk("mid_rst_stb", stb, 0);
    chk("mid_rst_fgo", prn_valid, 0);
    chk("mid_rst_fgi", kbd_ready, 1);
    chk("mid_rst_ien", ien, 0);
    tick(); #1;
    chk("mid_rst_idle", stb, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
